// File: rtl/cosim_pkg.sv
// Shared types and helpers for the cosim host endpoints.
// No logic; latency and backpressure are defined by the modules that import this package.
package cosim_pkg;

    localparam int COSIM_BYTE_W = 8;

    typedef logic [COSIM_BYTE_W-1:0] cosim_byte_t;

    function automatic int cosim_nbytes(input int bits);
        return (bits + COSIM_BYTE_W - 1) / COSIM_BYTE_W;
    endfunction

endpackage

// File: rtl/cosim_endpoint_from_host_if.sv
// Host byte stream in, reassembled message out. The slave modport is the endpoint.
// Latency and backpressure are set by the endpoint; the master drives host bytes and DataOutReady.
interface cosim_endpoint_from_host_if #(
    parameter int SIZE = 24
);
    import cosim_pkg::*;

    logic            host_valid;
    logic            host_ready;
    cosim_byte_t     host_data;
    logic            host_last;
    logic            DataOutValid;
    logic            DataOutReady;
    logic [SIZE-1:0] DataOut;
    logic            frame_err;

    modport master (
        output host_valid, host_data, host_last, DataOutReady,
        input  host_ready, DataOutValid, DataOut, frame_err
    );

    modport slave (
        input  host_valid, host_data, host_last, DataOutReady,
        output host_ready, DataOutValid, DataOut, frame_err
    );

endinterface

// File: rtl/cosim_msg_fifo.sv
// Show-ahead synchronous FIFO; head is registered so it holds its last value when empty.
// Latency: rdata valid the cycle after a push into an empty FIFO; push while full only succeeds with a pop.
module cosim_msg_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_nxt  = rd_ptr_q + 1'b1;
    assign rdata   = head_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_nxt;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        // The next head comes from storage, or straight from wdata when the FIFO drains to it.
        if (do_pop) begin
            if (count_q > CNT_W'(1)) begin
                head_d = mem_q[rd_nxt];
            end else if (do_push) begin
                head_d = wdata;
            end
        end else if (empty && do_push) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cosim_endpoint_from_host.sv
// Reassembles little-endian host byte frames into messages buffered for RTL; optional logging under COSIM_MSG_LOG_EN.
// Latency: DataOutValid the cycle after the final byte; host bytes stall only when a final byte meets a full, unpopped FIFO.
module cosim_endpoint_from_host
    import cosim_pkg::*;
#(
    parameter     ENDPOINT_ID         = "fromHost",
    parameter     FROM_HOST_TYPE_ID   = "i24",
    parameter int FROM_HOST_SIZE_BITS = 24,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    cosim_endpoint_from_host_if.slave  bus
);

    localparam int NB    = cosim_nbytes(FROM_HOST_SIZE_BITS);
    localparam int IDX_W = $clog2(NB + 1);
    localparam int ASM_W = NB * COSIM_BYTE_W;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FROM_HOST_SIZE_BITS < 1) begin : g_bad_cfg
        $error("cosim_endpoint_from_host: FIFO_DEPTH must be a power of 2 >= 2 and SIZE >= 1");
    end
    if ($bits(ENDPOINT_ID) == 0 || $bits(FROM_HOST_TYPE_ID) == 0) begin : g_bad_name
        $error("cosim_endpoint_from_host: endpoint name and type tag must be non-empty");
    end

    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [ASM_W-1:0]               asm_q, asm_d;
    logic [ASM_W-1:0]               word;
    logic                           frame_err_q, frame_err_d;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [FROM_HOST_SIZE_BITS-1:0] fifo_rdata;
    logic                           out_vld;
    logic                           pop;
    logic                           host_rdy;
    logic                           xfer;
    logic                           in_range;
    logic                           bad_len;
    cosim_byte_t                    byte_in;

    assign byte_in  = bus.host_data;
    assign out_vld  = rst & ~fifo_empty;
    assign pop      = out_vld & bus.DataOutReady;
    // Only a final byte needs a FIFO slot; a same-cycle pop frees one.
    assign host_rdy = rst & ~(fifo_full & bus.host_valid & bus.host_last & ~pop);
    assign xfer     = bus.host_valid & host_rdy;
    // idx_q saturates at NB, which marks every later byte as surplus.
    assign in_range = (idx_q < IDX_W'(NB));
    assign bad_len  = (idx_q != IDX_W'(NB - 1));

    always_comb begin
        word = asm_q;
        for (int k = 0; k < NB; k++) begin
            if (in_range && idx_q == IDX_W'(k)) begin
                word[k*COSIM_BYTE_W +: COSIM_BYTE_W] = byte_in;
            end
        end
    end

    always_comb begin
        idx_d       = idx_q;
        asm_d       = asm_q;
        frame_err_d = 1'b0;
        if (xfer) begin
            if (bus.host_last) begin
                idx_d       = '0;
                asm_d       = '0;
                frame_err_d = bad_len;
            end else begin
                asm_d = word;
                if (in_range) begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q       <= '0;
            asm_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            frame_err_q <= frame_err_d;
        end
    end

    cosim_msg_fifo #(
        .WIDTH (FROM_HOST_SIZE_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_msg_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer & bus.host_last),
        .wdata (word[FROM_HOST_SIZE_BITS-1:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.host_ready   = host_rdy;
    assign bus.DataOutValid = out_vld;
    assign bus.DataOut      = fifo_rdata;
    assign bus.frame_err    = rst & frame_err_q;

`ifdef COSIM_MSG_LOG_EN
    always_ff @(posedge clk) begin
        if (pop) begin
            $display("[%0t] %s recv'd: %h", $time, ENDPOINT_ID, bus.DataOut);
        end
        if (bus.frame_err) begin
            $display("[%0t] %s warning: %s message had wrong byte count", $time, ENDPOINT_ID, FROM_HOST_TYPE_ID);
        end
    end
`endif

endmodule

// File: tb/tb_cosim_endpoint_from_host.sv
// Directed bench for cosim_endpoint_from_host: framing, buffering, backpressure and reset.
module tb_cosim_endpoint_from_host;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ferr_cnt;
    logic [23:0] recv [$];

    cosim_endpoint_from_host_if #(.SIZE(24)) bus ();

    cosim_endpoint_from_host #(
        .ENDPOINT_ID         ("fromHost"),
        .FROM_HOST_TYPE_ID   ("i24"),
        .FROM_HOST_SIZE_BITS (24),
        .FIFO_DEPTH          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.DataOutValid === 1'b1 && bus.DataOutReady === 1'b1) recv.push_back(bus.DataOut);
        if (bus.frame_err === 1'b1) ferr_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input logic l, output int stalls);
        stalls = 0;
        @(posedge clk); #1;
        bus.host_valid = 1'b1;
        bus.host_data  = d;
        bus.host_last  = l;
        forever begin
            @(negedge clk);
            if (bus.host_ready === 1'b1) break;
            stalls++;
            if (stalls > 40) break;
        end
        @(posedge clk); #1;
        bus.host_valid = 1'b0;
        bus.host_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [23:0] v, output int stalls);
        int s;
        stalls = 0;
        send_byte(v[7:0], 1'b0, s);   stalls += s;
        send_byte(v[15:8], 1'b0, s);  stalls += s;
        send_byte(v[23:16], 1'b1, s); stalls += s;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.DataOutValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.DataOutValid); end
        checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL reset_host_ready: got %b expected 0", bus.host_ready); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.DataOut !== 24'h0) begin errors++; $display("FAIL reset_dataout: got %h expected 000000", bus.DataOut); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL post_reset_host_ready: got %b expected 1", bus.host_ready); end
    endtask

    task automatic test_basic;
        int s;
        int st;
        st = 0;
        recv.delete(); ferr_cnt = 0;
        bus.DataOutReady = 1'b1;
        send_byte(8'hC3, 1'b0, s); st += s;
        send_byte(8'hB2, 1'b0, s); st += s;
        @(negedge clk);
        checks++; if (bus.DataOutValid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.DataOutValid); end
        send_byte(8'hA1, 1'b1, s); st += s;
        @(negedge clk);
        checks++; if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 24'hA1B2C3) begin errors++; $display("FAIL basic_latency: got valid=%b data=%h expected valid=1 data=a1b2c3", bus.DataOutValid, bus.DataOut); end
        @(negedge clk);
        checks++; if (bus.DataOutValid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got valid=%b expected 0", bus.DataOutValid); end
        checks++; if (recv.size() != 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", recv.size()); end
        else begin checks++; if (recv[0] !== 24'hA1B2C3) begin errors++; $display("FAIL basic_data: got %h expected a1b2c3", recv[0]); end end
        checks++; if (ferr_cnt != 0 || st != 0) begin errors++; $display("FAIL basic_clean: got ferr=%0d stalls=%0d expected 0 0", ferr_cnt, st); end
    endtask

    task automatic test_backpressure;
        int s;
        int st;
        st = 0;
        recv.delete(); ferr_cnt = 0;
        bus.DataOutReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_msg(24'(i), s); st += s;
            @(negedge clk);
            checks++; if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 24'h000001) begin errors++; $display("FAIL bp_head_%0d: got valid=%b data=%h expected 1 000001", i, bus.DataOutValid, bus.DataOut); end
        end
        send_byte(8'h05, 1'b0, s); st += s;
        send_byte(8'h00, 1'b0, s); st += s;
        checks++; if (st != 0) begin errors++; $display("FAIL bp_early_stall: got %0d stalls expected 0", st); end
        @(posedge clk); #1;
        bus.host_valid = 1'b1; bus.host_data = 8'h00; bus.host_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.host_ready !== 1'b0 || bus.DataOut !== 24'h000001) begin errors++; $display("FAIL bp_stall_%0d: got ready=%b data=%h expected 0 000001", c, bus.host_ready, bus.DataOut); end
        end
        @(posedge clk); #1;
        bus.DataOutReady = 1'b1;
        @(negedge clk);
        checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ready=%b expected 1", bus.host_ready); end
        @(posedge clk); #1;
        bus.host_valid = 1'b0; bus.host_last = 1'b0;
        for (int c = 0; c < 30 && recv.size() < 5; c++) @(posedge clk);
        checks++; if (recv.size() != 5) begin errors++; $display("FAIL bp_drain_count: got %0d expected 5", recv.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (recv[i] !== 24'(i + 1)) begin errors++; $display("FAIL bp_order_%0d: got %h expected %h", i, recv[i], 24'(i + 1)); end
            end
        end
        @(negedge clk);
        checks++; if (bus.DataOutValid !== 1'b0 || ferr_cnt != 0) begin errors++; $display("FAIL bp_empty: got valid=%b ferr=%0d expected 0 0", bus.DataOutValid, ferr_cnt); end
    endtask

    task automatic test_frames;
        int s;
        recv.delete(); ferr_cnt = 0;
        bus.DataOutReady = 1'b1;
        send_byte(8'h11, 1'b0, s);
        send_byte(8'h22, 1'b1, s);
        repeat (3) @(negedge clk);
        checks++; if (recv.size() != 1 || ferr_cnt != 1) begin errors++; $display("FAIL short_counts: got msgs=%0d ferr=%0d expected 1 1", recv.size(), ferr_cnt); end
        else begin checks++; if (recv[0] !== 24'h002211) begin errors++; $display("FAIL short_data: got %h expected 002211", recv[0]); end end
        recv.delete(); ferr_cnt = 0;
        send_byte(8'h01, 1'b0, s);
        send_byte(8'h02, 1'b0, s);
        send_byte(8'h03, 1'b0, s);
        send_byte(8'h04, 1'b1, s);
        repeat (3) @(negedge clk);
        checks++; if (recv.size() != 1 || ferr_cnt != 1) begin errors++; $display("FAIL long_counts: got msgs=%0d ferr=%0d expected 1 1", recv.size(), ferr_cnt); end
        else begin checks++; if (recv[0] !== 24'h030201) begin errors++; $display("FAIL long_data: got %h expected 030201", recv[0]); end end
    endtask

    task automatic test_reset_mid;
        int s;
        recv.delete(); ferr_cnt = 0;
        bus.DataOutReady = 1'b1;
        send_byte(8'hAA, 1'b0, s);
        send_byte(8'hBB, 1'b0, s);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.DataOutValid !== 1'b0 || bus.host_ready !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got valid=%b ready=%b ferr=%b expected 0 0 0", bus.DataOutValid, bus.host_ready, bus.frame_err); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.DataOut !== 24'h0) begin errors++; $display("FAIL mid_reset_dataout: got %h expected 000000", bus.DataOut); end
        send_byte(8'h01, 1'b0, s);
        send_byte(8'h02, 1'b0, s);
        send_byte(8'h03, 1'b1, s);
        repeat (3) @(negedge clk);
        checks++; if (recv.size() != 1 || ferr_cnt != 0) begin errors++; $display("FAIL mid_reset_counts: got msgs=%0d ferr=%0d expected 1 0", recv.size(), ferr_cnt); end
        else begin checks++; if (recv[0] !== 24'h030201) begin errors++; $display("FAIL mid_reset_data: got %h expected 030201", recv[0]); end end
    endtask

    task automatic test_full_push_pop;
        int s;
        int st;
        st = 0;
        recv.delete(); ferr_cnt = 0;
        bus.DataOutReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_msg(24'h000010 + 24'(i), s); st += s;
        end
        send_byte(8'h14, 1'b0, s); st += s;
        send_byte(8'h00, 1'b0, s); st += s;
        @(posedge clk); #1;
        bus.host_valid = 1'b1; bus.host_data = 8'h00; bus.host_last = 1'b1;
        bus.DataOutReady = 1'b1;
        @(negedge clk);
        checks++; if (bus.host_ready !== 1'b1 || st != 0) begin errors++; $display("FAIL pp_ready: got ready=%b stalls=%0d expected 1 0", bus.host_ready, st); end
        @(posedge clk); #1;
        bus.host_valid = 1'b0; bus.host_last = 1'b0;
        bus.DataOutReady = 1'b0;
        @(negedge clk);
        checks++; if (bus.DataOutValid !== 1'b1 || bus.DataOut !== 24'h000011 || recv.size() != 1) begin errors++; $display("FAIL pp_same_cycle: got valid=%b data=%h msgs=%0d expected 1 000011 1", bus.DataOutValid, bus.DataOut, recv.size()); end
        @(posedge clk); #1;
        bus.DataOutReady = 1'b1;
        for (int c = 0; c < 30 && recv.size() < 5; c++) @(posedge clk);
        checks++; if (recv.size() != 5) begin errors++; $display("FAIL pp_count: got %0d expected 5", recv.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (recv[i] !== 24'h000010 + 24'(i)) begin errors++; $display("FAIL pp_order_%0d: got %h expected %h", i, recv[i], 24'h000010 + 24'(i)); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ferr_cnt = 0;
        rst = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_data = 8'h00;
        bus.host_last = 1'b0;
        bus.DataOutReady = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_frames();
        test_reset_mid();
        test_full_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
